// File: rtl/shamt_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter with a Start/Busy/Done handshake.
// Define SHAMT_SHIFT_ROTATE_EN to make Op = 11 a rotate-right (ROR).
module shamt_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand,
  input  logic [31:0]      ShiftAmt,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] step_n;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             unused_shamt_hi;

  // Only the low five shamt bits carry an amount.
  assign unused_shamt_hi = ^ShiftAmt[31:CNT_W];

  // Single-position shift for the given op.
  function automatic logic [WIDTH-1:0] shift1(input logic [1:0] op,
                                              input logic [WIDTH-1:0] v);
    case (op)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, v[WIDTH-1:1]};
      OP_SRA:  return {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SHAMT_SHIFT_ROTATE_EN
      default: return {v[0], v[WIDTH-1:1]};
`else
      default: return v;
`endif
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    step_n  = '0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          work_d = Operand;
          op_d   = Op;
          cnt_d  = ShiftAmt[CNT_W-1:0];
`ifndef SHAMT_SHIFT_ROTATE_EN
          // Reserved op behaves as a zero-amount pass-through.
          if (Op == OP_ROR) cnt_d = '0;
`endif
          state_d = (cnt_d == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        step_n = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        for (int i = 0; i < int'(STEP); i++) begin
          if (CNT_W'(i) < step_n) work_d = shift1(op_q, work_d);
        end
        cnt_d = cnt_q - step_n;
        if (cnt_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Result = work_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_shamt_shift_unit.sv
// Directed bench for shamt_shift_unit; STEP=1 and STEP=4 instances share stimulus.
module tb_shamt_shift_unit;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand;
  logic [31:0] ShiftAmt;
  logic [31:0] res1, res4;
  logic        busy1, busy4, done1, done4;

  int n_checks;
  int n_pass;

  shamt_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Operand(Operand),
    .ShiftAmt(ShiftAmt), .Result(res1), .Busy(busy1), .Done(done1)
  );

  shamt_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Operand(Operand),
    .ShiftAmt(ShiftAmt), .Result(res4), .Busy(busy4), .Done(done4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Pulse Start for one edge; returns 1 time unit after the sampling edge.
  task automatic do_start(input logic [1:0] op, input logic [31:0] opnd, input logic [31:0] amt);
    @(negedge Clk);
    Start = 1'b1; Op = op; Operand = opnd; ShiftAmt = amt;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Count edges (Start edge = 1) until Done, then check latency, result and pulse width.
  task automatic wait_done(input bit sel, input int lat0, input int exp_lat,
                           input logic [31:0] exp_res, input string tag);
    int lat;
    bit seen;
    lat  = lat0;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      if (sel ? done4 : done1) seen = 1'b1;
      else begin
        @(posedge Clk); #1;
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, sel ? res4 : res1, exp_res);
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, 32'(sel ? done4 : done1), 32'd0);
    check({tag, "_busy_clr"}, 32'(sel ? busy4 : busy1), 32'd0);
    check({tag, "_result_hold"}, sel ? res4 : res1, exp_res);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    int ndone;
    n_checks = 0; n_pass = 0;
    Rst = 1'b1; Start = 1'b0; Op = 2'b00; Operand = '0; ShiftAmt = '0;

    // Reset and quiet idle
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    check("rst_result", res1, 32'h0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_result4", res4, 32'h0);
    idle(5);
    check("idle_result", res1, 32'h0);
    check("idle_busy", 32'(busy1 | busy4), 32'd0);
    check("idle_done", 32'(done1 | done4), 32'd0);

    // SLL 1 by 4, STEP=1
    do_start(2'b00, 32'h0000_0001, 32'h0000_0004);
    check("sll_busy", 32'(busy1), 32'd1);
    wait_done(1'b0, 1, 5, 32'h0000_0010, "sll4");
    idle(40);

    // SRA / SRL by 31 with upper shamt bits set
    do_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, 1, 32, 32'hFFFF_FFFF, "sra31");
    idle(40);
    do_start(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, 1, 32, 32'h0000_0001, "srl31");
    idle(40);

    // Zero amount, then Start during DONE is ignored
    do_start(2'b01, 32'hDEAD_BEEF, 32'h0000_0000);
    check("amt0_done", 32'(done1), 32'd1);
    check("amt0_result", res1, 32'hDEAD_BEEF);
    check("amt0_result4", res4, 32'hDEAD_BEEF);
    @(negedge Clk);
    Start = 1'b1; Operand = 32'h1111_1111; ShiftAmt = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("done_start_busy", 32'(busy1), 32'd0);
    check("done_start_done", 32'(done1), 32'd0);
    check("done_start_result", res1, 32'hDEAD_BEEF);
    idle(5);
    check("done_start_still_idle", 32'(busy1), 32'd0);

    // Amount 32 truncates to 0
    do_start(2'b00, 32'h0000_00A5, 32'h0000_0020);
    wait_done(1'b0, 1, 1, 32'h0000_00A5, "amt32");
    idle(5);

    // STEP=4 SRL by 10 with a Start pulse mid-operation
    do_start(2'b01, 32'hF000_0000, 32'd10);
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; Operand = 32'h0000_0000; ShiftAmt = 32'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(1'b1, 2, 4, 32'h003C_0000, "srl10_step4");
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      if (done4) ndone++;
    end
    check("step4_no_second_done", 32'(ndone), 32'd0);
    check("step4_result_kept", res4, 32'h003C_0000);
    idle(40);

    // Reset during SHIFT
    do_start(2'b00, 32'h0000_0001, 32'd20);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_done", 32'(done1), 32'd0);
    check("midrst_result", res1, 32'h0);
    Rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (done1 || done4) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);

    // Op = 11
`ifdef SHAMT_SHIFT_ROTATE_EN
    do_start(2'b11, 32'h0000_0001, 32'd1);
    wait_done(1'b0, 1, 2, 32'h8000_0000, "ror1");
`else
    do_start(2'b11, 32'h1234_5678, 32'd5);
    wait_done(1'b0, 1, 1, 32'h1234_5678, "op11_pass");
`endif
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shamt_shift_unit.md
Name: shamt_shift_unit

Overview:
- Multi-cycle shifter for the ALU shift path.
- Consumes the 32-bit shift amount produced by the 5-to-32 shamt extension stage and shifts an operand over several cycles: SLL, SRL or SRA.
- Uses a Start/Busy/Done handshake with the datapath controller. Frees the single-cycle ALU from a full barrel shifter.

Parameters:
- WIDTH, 32: operand/result width.
- STEP, 1: maximum bit positions shifted per cycle. Legal values are 1, 2, 4, 8.

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Rst, input, 1: synchronous reset, active-high.
- Start, input, 1: request; sampled only in IDLE.
- Op, input, 2: operation. 00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved or ROR (see Optional Feature).
- Operand, input, WIDTH: value to shift; captured on accepted Start.
- ShiftAmt, input, 32: extended shamt. Only bits [4:0] are used; bits [31:5] are ignored.
- Result, output, WIDTH: shifted value; valid when Done is high and held until the next accepted Start.
- Busy, output, 1: high in SHIFT and DONE states.
- Done, output, 1: one-cycle pulse when Result is valid.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst.
- Reset values: state IDLE, Result = 0, Busy = 0, Done = 0, internal counter = 0, captured Op = 00.
- Rst has priority over everything. Asserting it mid-operation aborts the shift, and outputs return to reset values on the next edge.
- States:
  - IDLE: on an edge with Start = 1, capture Operand into the working register, ShiftAmt[4:0] into the counter, and Op. Go to DONE if the amount is 0, else go to SHIFT.
  - SHIFT: each edge, shift the working register by n = min(STEP, counter) and set counter = counter - n. When the counter reaches 0, go to DONE. The working register drives Result continuously.
  - DONE: Done = 1 for exactly this one cycle. Next edge returns to IDLE.
- Shift fill rules:
  - SLL fills with zeros from the LSB end.
  - SRL fills with zeros from the MSB end.
  - SRA replicates bit WIDTH-1 of the working register.
- Latency from the Start edge to Done high: 1 + ceil(amt/STEP) cycles. Amount 0 gives Done on the cycle after Start, with Result = Operand.
- Start while Busy = 1 is ignored. No queuing; Operand, Op and ShiftAmt changes are ignored.
- Start in the same cycle as Done (DONE state) is ignored. The earliest accepted Start is the cycle after Done, in IDLE.
- Maximum amount is 31. Amounts of 32 or more are impossible because only 5 bits are used.
- Result is stable from Done until the next accepted Start, then tracks the working register.

Optional Feature:
- Macro: SHAMT_SHIFT_ROTATE_EN.
- Defined: Op = 11 is ROR. Each step rotates right by n, with bits leaving the LSB re-entering at the MSB. Latency is the same as other ops.
- Not defined: Op = 11 is treated as amount 0. The block goes IDLE to DONE with Result = Operand, Done one cycle after Start, and no shifting.

Test Plan:
1. Rst high for 2 cycles, then low. Expect Result = 0, Busy = 0, Done = 0. Start = 0 for 5 cycles: no change.
2. STEP = 1, Op = SLL, Operand = 0x0000_0001, ShiftAmt = 0x0000_0004. Expect Busy high next cycle, Done pulse 5 cycles after Start, Result = 0x0000_0010.
3. STEP = 1, Op = SRA, Operand = 0x8000_0000, ShiftAmt = 0xFFFF_FFFF (amount 31, upper bits ignored). Expect Done after 32 cycles, Result = 0xFFFF_FFFF. Repeat with SRL: expect Result = 0x0000_0001.
4. ShiftAmt = 0, Op = SRL, Operand = 0xDEAD_BEEF. Expect Done the cycle after Start, Result = 0xDEAD_BEEF.
5. STEP = 4, Op = SRL, Operand = 0xF000_0000, amount 10. Expect Done 4 cycles after Start (steps 4, 4, 2), Result = 0x003C_0000. A second Start pulsed mid-operation is ignored, with no second Done.
6. Rst asserted during SHIFT (amount 20, cycle 5). Expect the next edge to give Busy = 0, Done = 0, Result = 0, and no Done pulse afterward. With the macro defined: ROR of 0x0000_0001 by 1 gives 0x8000_0000.
